// File: rtl/rx_frame_pkg.sv
// Shared constants for the oversampling UART receiver: state encoding and sample positions.
// The counter is 3 bits wide, so only 8x oversampling fits.
package rx_frame_pkg;

    localparam int OVERSAMPLE = 8;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic [2:0] SAMPLE_FIRST = 3'd3;
    localparam logic [2:0] SAMPLE_MID   = 3'd4;
    localparam logic [2:0] SAMPLE_LAST  = 3'd5;
    localparam logic [2:0] BIT_END      = 3'd7;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/rx_majority_vote.sv
// Majority-of-three bit decision: holds the samples at counts 3 and 4 and votes with the live
// sample, so the result is usable combinationally on the count-5 acquisition pulse.
module rx_majority_vote
    import rx_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sampleEn,
    input  logic [2:0] sampleCnt,
    input  logic       rxBit,
    output logic       bitVal
);

    logic sampleA;
    logic sampleB;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sampleA <= 1'b1;
            sampleB <= 1'b1;
        end else if (sampleEn) begin
            if (sampleCnt == SAMPLE_FIRST) sampleA <= rxBit;
            if (sampleCnt == SAMPLE_MID)   sampleB <= rxBit;
        end
    end

    assign bitVal = majority3(sampleA, sampleB, rxBit);

endmodule

// File: rtl/rx_frame_decoder.sv
// 8x oversampled async serial receiver; byte + flags appear 1 clk after the stop decision.
// Holding register with valid/ready: a byte completing while unaccepted is dropped with OverrunErr_o.
// Optional parity bit enabled by defining RX_PARITY_EN (adds ParityOdd_i).
module rx_frame_decoder #(
    parameter int OVERSAMPLE = rx_frame_pkg::OVERSAMPLE,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 AcqSig_i,
    input  logic                 RxEn_i,
    input  logic                 Rx_i,
    output logic [DATA_BITS-1:0] Data_o,
    output logic                 DataValid_o,
    input  logic                 DataReady_i,
    output logic                 FrameErr_o,
    output logic                 ParityErr_o,
    output logic                 OverrunErr_o,
    output logic                 Busy_o
`ifdef RX_PARITY_EN
    ,
    input  logic                 ParityOdd_i
`endif
);
    import rx_frame_pkg::*;

    // Only 8x is supported; the 3-bit counter wraps naturally at the bit end.
    localparam logic [2:0] LAST_CNT = (OVERSAMPLE == 8) ? BIT_END : 3'(OVERSAMPLE - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    logic                 rxMeta;
    logic                 rxSync;
    logic [2:0]           state;
    logic [2:0]           sampleCnt;
    logic [2:0]           bitIdx;
    logic [DATA_BITS-1:0] shiftReg;
    logic                 bitVal;
    logic                 frameDone;
`ifdef RX_PARITY_EN
    logic                 parityBad;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta <= 1'b1;
            rxSync <= 1'b1;
        end else begin
            rxMeta <= Rx_i;
            rxSync <= rxMeta;
        end
    end

    rx_majority_vote uVote (
        .clk       (clk),
        .rst       (rst),
        .sampleEn  (AcqSig_i),
        .sampleCnt (sampleCnt),
        .rxBit     (rxSync),
        .bitVal    (bitVal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            sampleCnt <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
`ifdef RX_PARITY_EN
            parityBad <= 1'b0;
`endif
        end else if (!RxEn_i) begin
            state     <= ST_IDLE;
            sampleCnt <= '0;
            bitIdx    <= '0;
        end else if (AcqSig_i) begin
            case (state)
                ST_IDLE: begin
                    if (!rxSync) begin
                        state     <= ST_START;
                        sampleCnt <= '0;
                    end
                end
                ST_START: begin
                    if (sampleCnt == SAMPLE_LAST && bitVal) begin
                        state     <= ST_IDLE;
                        sampleCnt <= '0;
                    end else if (sampleCnt == LAST_CNT) begin
                        state     <= ST_DATA;
                        sampleCnt <= '0;
                        bitIdx    <= '0;
                    end else begin
                        sampleCnt <= sampleCnt + 3'd1;
                    end
                end
                ST_DATA: begin
                    if (sampleCnt == SAMPLE_LAST)
                        shiftReg <= {bitVal, shiftReg[DATA_BITS-1:1]};
                    if (sampleCnt == LAST_CNT && bitIdx == LAST_BIT) begin
`ifdef RX_PARITY_EN
                        state     <= ST_PARITY;
`else
                        state     <= ST_STOP;
`endif
                        sampleCnt <= '0;
                        bitIdx    <= '0;
                    end else begin
                        if (sampleCnt == LAST_CNT) bitIdx <= bitIdx + 3'd1;
                        sampleCnt <= sampleCnt + 3'd1;
                    end
                end
`ifdef RX_PARITY_EN
                ST_PARITY: begin
                    // Even parity expects the bit to equal the XOR of the data; odd inverts it.
                    if (sampleCnt == SAMPLE_LAST)
                        parityBad <= bitVal ^ (^shiftReg) ^ ParityOdd_i;
                    if (sampleCnt == LAST_CNT) begin
                        state     <= ST_STOP;
                        sampleCnt <= '0;
                    end else begin
                        sampleCnt <= sampleCnt + 3'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (sampleCnt == SAMPLE_LAST) begin
                        state     <= ST_IDLE;
                        sampleCnt <= '0;
                    end else begin
                        sampleCnt <= sampleCnt + 3'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    sampleCnt <= '0;
                end
            endcase
        end
    end

    assign frameDone = RxEn_i && AcqSig_i && (state == ST_STOP) && (sampleCnt == SAMPLE_LAST);
    assign Busy_o    = (state != ST_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Data_o       <= '0;
            DataValid_o  <= 1'b0;
            FrameErr_o   <= 1'b0;
            OverrunErr_o <= 1'b0;
`ifdef RX_PARITY_EN
            ParityErr_o  <= 1'b0;
`endif
        end else begin
            OverrunErr_o <= 1'b0;
            if (frameDone) begin
                // A pending byte is only replaced if it is being accepted this same clk.
                if (!DataValid_o || DataReady_i) begin
                    Data_o      <= shiftReg;
                    FrameErr_o  <= ~bitVal;
                    DataValid_o <= 1'b1;
`ifdef RX_PARITY_EN
                    ParityErr_o <= parityBad;
`endif
                end else begin
                    OverrunErr_o <= 1'b1;
                end
            end else if (DataValid_o && DataReady_i) begin
                DataValid_o <= 1'b0;
            end
        end
    end

`ifndef RX_PARITY_EN
    assign ParityErr_o = 1'b0;
`endif

endmodule
